lcd_bus_receiver: RTL and testbench

Receiving end of the 8080-style parallel LCD write bus: synchronizes an externally driven 8-bit bus (cs_n, wr_n, rs, data) into the fabric clock domain and captures one byte per write strobe. Delivers {rs, data} through a small show-ahead FIFO on a valid/ready stream. Tracks the current command byte and parameter index, and flags memory-write (0x2C) frame starts. Sits between the LCD bus pins and any fabric logic that needs to observe or intercept host-issued display traffic.

---
 rtl/lcd_bus_receiver.sv | 120 ++++++++++++
 tb/tb_lcd_bus_receiver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// 8080-style LCD write-bus receiver: synchronizes the bus, captures one byte per
// wr_n rising edge, queues {rs, data} in a show-ahead FIFO and tracks command/params.
module lcd_bus_receiver #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_bus_cs_n,
  input  logic       i_bus_wr_n,
  input  logic       i_bus_rs,
  input  logic [7:0] i_bus_data,
  output logic       o_valid,
  output logic       o_rs,
  output logic [7:0] o_data,
  input  logic       i_ready,
  output logic       o_overflow,
  input  logic       i_clear_overflow,
  output logic [7:0] o_cmd,
  output logic [7:0] o_param_idx,
  output logic       o_frame_start
);

  localparam int unsigned           DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [7:0]            CMD_RAMWR  = 8'h2C;

  logic       cs_s1_q, cs_s2_q, wr_s1_q, wr_s2_q, rs_s1_q, rs_s2_q;
  logic [7:0] data_s1_q, data_s2_q;

  logic [8:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            cmd_q, cmd_d, pidx_q, pidx_d;
  logic                  fs_q, fs_d;

  logic capture, full, pop, push, drop;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      wr_s1_q   <= 1'b1;
      wr_s2_q   <= 1'b1;
      rs_s1_q   <= 1'b0;
      rs_s2_q   <= 1'b0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      cs_s1_q   <= i_bus_cs_n;
      cs_s2_q   <= cs_s1_q;
      wr_s1_q   <= i_bus_wr_n;
      wr_s2_q   <= wr_s1_q;
      rs_s1_q   <= i_bus_rs;
      rs_s2_q   <= rs_s1_q;
      data_s1_q <= i_bus_data;
      data_s2_q <= data_s1_q;
    end
  end

  always_comb begin
    // s2 still holds the last low-phase sample when s1 first sees wr_n high
    capture  = wr_s1_q & ~wr_s2_q & ~cs_s2_q;
    full     = (count_q == FULL_COUNT);
    pop      = (count_q != '0) && i_ready;
    push     = capture && (!full || pop);
    drop     = capture && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
    ovf_d    = drop ? 1'b1 : (i_clear_overflow ? 1'b0 : ovf_q);

    cmd_d  = cmd_q;
    pidx_d = pidx_q;
    fs_d   = 1'b0;
    if (capture) begin
      if (!rs_s2_q) begin
        cmd_d  = data_s2_q;
        pidx_d = '0;
        fs_d   = (data_s2_q == CMD_RAMWR);
      end else if (pidx_q != '1) begin
        pidx_d = pidx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cmd_q    <= '0;
      pidx_q   <= '0;
      fs_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cmd_q    <= cmd_d;
      pidx_q   <= pidx_d;
      fs_q     <= fs_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {rs_s2_q, data_s2_q};
  end

  always_comb begin
    o_valid       = (count_q != '0);
    {o_rs, o_data} = o_valid ? mem_q[rd_ptr_q] : '0;
    o_overflow    = ovf_q;
    o_cmd         = cmd_q;
    o_param_idx   = pidx_q;
    o_frame_start = fs_q;
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: directed and random bus writes compared
// against a transaction-level queue model of the stream and command tracker.
module tb_lcd_bus_receiver;

  localparam int unsigned DEPTH_LOG2 = 2;
  localparam int          DEPTH      = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n  = 1'b1;
  logic       wr_n  = 1'b1;
  logic       rs    = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       ready = 1'b0;
  logic       clr   = 1'b0;

  logic       o_valid, o_rs, o_overflow, o_frame_start;
  logic [7:0] o_data, o_cmd, o_param_idx;

  always #5 clk = ~clk;

  lcd_bus_receiver #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_bus_cs_n       (cs_n),
    .i_bus_wr_n       (wr_n),
    .i_bus_rs         (rs),
    .i_bus_data       (data),
    .o_valid          (o_valid),
    .o_rs             (o_rs),
    .o_data           (o_data),
    .i_ready          (ready),
    .o_overflow       (o_overflow),
    .i_clear_overflow (clr),
    .o_cmd            (o_cmd),
    .o_param_idx      (o_param_idx),
    .o_frame_start    (o_frame_start)
  );

  int errors = 0;
  int checks = 0;

  logic [8:0] mq[$];
  logic       m_ovf  = 1'b0;
  logic [7:0] m_cmd  = 8'h00;
  int         m_pidx = 0;
  logic       m_fs   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [8:0] head;
    head = (mq.size() != 0) ? mq[0] : 9'h000;
    check({tag, ".valid"}, o_valid, (mq.size() != 0));
    check({tag, ".rs"}, o_rs, head[8]);
    check({tag, ".data"}, o_data, head[7:0]);
    check({tag, ".ovf"}, o_overflow, m_ovf);
    check({tag, ".cmd"}, o_cmd, m_cmd);
    check({tag, ".pidx"}, o_param_idx, m_pidx);
    check({tag, ".fs"}, o_frame_start, m_fs);
  endtask

  // One clock edge of the reference: pop first, then push, then tracker.
  task automatic model_edge(input logic cap, input logic brs, input logic [7:0] d,
                            input logic rdy, input logic clrv);
    logic dropped;
    dropped = 1'b0;
    m_fs    = 1'b0;
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (cap) begin
      if (mq.size() < DEPTH) mq.push_back({brs, d});
      else dropped = 1'b1;
      if (!brs) begin
        m_cmd  = d;
        m_pidx = 0;
        m_fs   = (d == 8'h2C);
      end else if (m_pidx < 255) begin
        m_pidx = m_pidx + 1;
      end
    end
    m_ovf = dropped ? 1'b1 : (clrv ? 1'b0 : m_ovf);
  endtask

  task automatic bus_write(input logic cs, input logic brs, input logic [7:0] d,
                           input logic rdy, input logic clrv, input string tag);
    @(negedge clk);
    ready = 1'b0; clr = 1'b0;
    cs_n = cs; rs = brs; data = d; wr_n = 1'b0;
    @(posedge clk);
    m_fs = 1'b0;
    repeat (3) @(negedge clk);
    wr_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = rdy; clr = clrv;
    @(posedge clk);
    model_edge(!cs, brs, d, rdy, clrv);
    #1 check_state(tag);
  endtask

  task automatic idle(input logic rdy, input logic clrv, input string tag);
    @(negedge clk);
    ready = rdy; clr = clrv;
    @(posedge clk);
    model_edge(1'b0, 1'b0, 8'h00, rdy, clrv);
    #1 check_state(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_cmd = 8'h00; m_pidx = 0; m_fs = 1'b0;
  endtask

  initial begin
    logic cs_r, rs_r, rdy_r, clr_r;
    logic [7:0] d_r;

    repeat (2) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    idle(1'b0, 1'b0, "post_reset");

    // single command 0x2A, stream valid for exactly one cycle with ready held
    bus_write(1'b0, 1'b0, 8'h2A, 1'b1, 1'b0, "t1_cap");
    @(posedge clk);
    model_edge(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #1 check_state("t1_drain");

    // memory-write command plus three parameters
    bus_write(1'b0, 1'b0, 8'h2C, 1'b0, 1'b0, "t2_cmd");
    idle(1'b0, 1'b0, "t2_fsdrop");
    bus_write(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, "t2_p1");
    bus_write(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, "t2_p2");
    bus_write(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, "t2_p3");
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, "t2_pop");

    // overflow, then clear coinciding with another drop
    for (int i = 1; i <= 6; i++) bus_write(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, "t3_fill");
    bus_write(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, "t3_clr_vs_drop");
    idle(1'b0, 1'b1, "t3_clr");

    // push and pop together while full
    bus_write(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, "t5_full_pushpop");

    // deselected strobe is ignored
    bus_write(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, "t4_csn");
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0, "t5_drain");
    idle(1'b1, 1'b0, "pop_empty");

    // push and pop together with one entry queued
    bus_write(1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "c1_a");
    bus_write(1'b0, 1'b1, 8'h20, 1'b1, 1'b0, "c1_swap");
    idle(1'b1, 1'b0, "c1_drain");

    // parameter index saturation
    for (int i = 0; i < 258; i++) bus_write(1'b0, 1'b1, 8'(i), 1'b1, 1'b0, "sat");
    idle(1'b1, 1'b1, "sat_clr");

    // random traffic
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        cs_r  = ($urandom_range(0, 7) == 0);
        rs_r  = 1'($urandom_range(0, 1));
        d_r   = ($urandom_range(0, 3) == 0) ? 8'h2C : 8'($urandom);
        rdy_r = 1'($urandom_range(0, 1));
        clr_r = ($urandom_range(0, 5) == 0);
        bus_write(cs_r, rs_r, d_r, rdy_r, clr_r, "rnd_wr");
      end else begin
        idle(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), "rnd_idle");
      end
    end

    // asynchronous reset mid-strobe with entries queued
    while (mq.size() > 0) idle(1'b1, 1'b0, "rst_prep_drain");
    bus_write(1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, "rst_q1");
    bus_write(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, "rst_q2");
    bus_write(1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, "rst_q3");
    @(negedge clk);
    cs_n = 1'b0; rs = 1'b1; data = 8'hAB; wr_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_state("rst_async");
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, "rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
